// File: rtl/i2s_rx_deser.sv
// rtl/i2s_rx_deser.sv - I2S receive deserialiser delivering stereo frames on a valid/ready port
// Optional slot-length frame check is enabled by defining I2S_RX_FRAME_CHECK_EN.
module i2s_rx_deser #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bclk,
    input  logic              lrclk,
    input  logic              sdin,
    output logic [DATA_W-1:0] sample_l,
    output logic [DATA_W-1:0] sample_r,
    output logic              sample_valid,
    input  logic              sample_ready,
    output logic              overrun,
    output logic              frame_err
);
    localparam int            CW      = $clog2(DATA_W + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DATA_W);

    typedef enum logic [1:0] {HUNT, LEFT, RIGHT} state_t;
    state_t state, state_d;

    logic              bclk_s1, bclk_s2, bclk_d;
    logic              lr_s1, lr, sd_s1, sd;
    logic              lr_prev;
    logic [CW-1:0]     cnt;
    logic [DATA_W-1:0] sh, word, hold_l;
    logic              brise, trans, latch_l, close_r, bad, deliver;

    assign brise = bclk_s2 & ~bclk_d;
    assign trans = brise & (lr != lr_prev);

    // sh is kept left-justified, so the current bit lands at position DATA_W-1-cnt
    always_comb begin
        word = sh;
        for (int i = 0; i < DATA_W; i++) begin
            if (cnt == CW'(DATA_W - 1 - i)) begin
                word[i] = sd;
            end
        end
    end

    always_comb begin
        state_d = state;
        latch_l = 1'b0;
        close_r = 1'b0;
        case (state)
            HUNT: begin
                if (trans && !lr) begin
                    state_d = LEFT;
                end
            end
            LEFT: begin
                if (trans && lr) begin
                    latch_l = 1'b1;
                    state_d = RIGHT;
                end
            end
            RIGHT: begin
                if (trans && !lr) begin
                    close_r = 1'b1;
                    state_d = LEFT;
                end
            end
            default: state_d = HUNT;
        endcase
    end

    assign deliver = close_r & ~bad;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= HUNT;
        end else begin
            state <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bclk_s1      <= 1'b0;
            bclk_s2      <= 1'b0;
            bclk_d       <= 1'b0;
            lr_s1        <= 1'b0;
            lr           <= 1'b0;
            sd_s1        <= 1'b0;
            sd           <= 1'b0;
            lr_prev      <= 1'b0;
            cnt          <= '0;
            sh           <= '0;
            hold_l       <= '0;
            sample_l     <= '0;
            sample_r     <= '0;
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            bclk_s1 <= bclk;
            bclk_s2 <= bclk_s1;
            bclk_d  <= bclk_s2;
            lr_s1   <= lrclk;
            lr      <= lr_s1;
            sd_s1   <= sdin;
            sd      <= sd_s1;

            if (brise) begin
                lr_prev <= lr;
                if (trans) begin
                    cnt <= '0;
                    sh  <= '0;
                end else begin
                    sh <= word;
                    if (cnt < CNT_MAX) begin
                        cnt <= cnt + 1'b1;
                    end
                end
            end

            if (latch_l) begin
                hold_l <= word;
            end

            // a delivery coinciding with acceptance is not an overrun
            if (deliver) begin
                sample_l     <= hold_l;
                sample_r     <= word;
                sample_valid <= 1'b1;
                if (sample_valid && !sample_ready) begin
                    overrun <= 1'b1;
                end
            end else if (sample_ready) begin
                sample_valid <= 1'b0;
            end
        end
    end

`ifdef I2S_RX_FRAME_CHECK_EN
    logic [5:0] len, len_l, len_cur;

    assign len_cur = (len == 6'd63) ? len : len + 6'd1;
    assign bad     = (len_l != len_cur) || (len_cur < 6'(DATA_W));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            len       <= '0;
            len_l     <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= close_r & bad;
            if (brise) begin
                len <= trans ? 6'd0 : len_cur;
            end
            if (latch_l) begin
                len_l <= len_cur;
            end
        end
    end
`else
    assign bad       = 1'b0;
    assign frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_i2s_rx_deser.sv
// tb/tb_i2s_rx_deser.sv - self-checking bench for i2s_rx_deser
module tb_i2s_rx_deser;
    localparam int DW = 16;
`ifdef I2S_RX_FRAME_CHECK_EN
    localparam bit FC = 1'b1;
`else
    localparam bit FC = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          bclk;
    logic          lrclk;
    logic          sdin;
    logic [DW-1:0] sample_l;
    logic [DW-1:0] sample_r;
    logic          sample_valid;
    logic          sample_ready;
    logic          overrun;
    logic          frame_err;

    int n_tests = 0;
    int n_fail  = 0;
    int n_acc   = 0;

    i2s_rx_deser #(.DATA_W(DW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bclk         (bclk),
        .lrclk        (lrclk),
        .sdin         (sdin),
        .sample_l     (sample_l),
        .sample_r     (sample_r),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .overrun      (overrun),
        .frame_err    (frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (sample_valid && sample_ready) begin
            n_acc <= n_acc + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // first DATA_W bits of an n-bit MSB-first slot, zero padded on the right
    function automatic logic [DW-1:0] exp_word(input logic [63:0] v, input int n);
        if (n >= DW) begin
            return DW'(v >> (n - DW));
        end
        return DW'(v << (DW - n));
    endfunction

    function automatic logic is_good(input int nl, input int nr);
        return !FC || (nl == nr && nl >= DW);
    endfunction

    task automatic send_rise(input logic lr, input logic b);
        bclk  = 1'b0;
        lrclk = lr;
        sdin  = b;
        repeat (3) @(negedge clk);
        bclk = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic lone_right(input int n);
        for (int i = 0; i < n; i++) send_rise(1'b1, 1'($urandom));
        send_rise(1'b0, 1'($urandom));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) begin
            bclk  = ~bclk;
            lrclk = 1'($urandom);
            sdin  = 1'($urandom);
            @(negedge clk);
        end
        check("rst_sample_l", sample_l, 0);
        check("rst_sample_r", sample_r, 0);
        check("rst_valid", sample_valid, 0);
        check("rst_overrun", overrun, 0);
        check("rst_frame_err", frame_err, 0);
        rst_n = 1'b1;
        bclk  = 1'b0;
        lrclk = 1'b1;
        sdin  = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_frame(input logic [63:0] vl, input int nl, input logic [63:0] vr,
                              input int nr, input logic pre_valid, input logic pulse);
        logic          good;
        logic [DW-1:0] el, er;
        good = is_good(nl, nr);
        el   = exp_word(vl, nl);
        er   = exp_word(vr, nr);
        for (int i = 0; i < nl; i++) send_rise(i == nl - 1, vl[nl-1-i]);
        for (int i = 0; i < nr - 1; i++) send_rise(1'b1, vr[nr-1-i]);
        bclk  = 1'b0;
        lrclk = 1'b0;
        sdin  = vr[0];
        repeat (3) @(negedge clk);
        bclk = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("valid_before_e2", sample_valid, pre_valid);
        if (pulse) sample_ready = 1'b1;
        @(negedge clk);
        if (pulse) sample_ready = 1'b0;
        check("frame_err_at_e2", frame_err, !good);
        check("valid_at_e2", sample_valid, good | pre_valid);
        if (good) begin
            check("sample_l", sample_l, el);
            check("sample_r", sample_r, er);
        end
        @(negedge clk);
        check("frame_err_pulse_end", frame_err, 0);
        if (sample_ready) check("valid_single_pulse", sample_valid, 0);
    endtask

    initial begin
        int            acc0;
        int            ngood;
        int            nl, nr;
        logic [63:0]   vl, vr;
        rst_n        = 1'b0;
        bclk         = 1'b0;
        lrclk        = 1'b0;
        sdin         = 1'b0;
        sample_ready = 1'b0;
        @(negedge clk);
        do_reset();

        lone_right(16);
        repeat (2) @(negedge clk);
        check("lone_right_no_valid", sample_valid, 0);

        sample_ready = 1'b1;
        acc0  = n_acc;
        ngood = 0;
        send_frame({32'd0, 16'h1234, 16'($urandom)}, 32, {32'd0, 16'hABCD, 16'($urandom)}, 32, 1'b0, 1'b0);
        ngood += 1;
        send_frame(64'hABC, 12, 64'h123, 12, 1'b0, 1'b0);
        ngood += int'(is_good(12, 12));
        for (int k = 0; k < 6; k++) begin
            nl = $urandom_range(8, 40);
            nr = ($urandom_range(0, 1) == 0) ? nl : $urandom_range(8, 40);
            vl = {$urandom, $urandom} & ((64'd1 << nl) - 64'd1);
            vr = {$urandom, $urandom} & ((64'd1 << nr) - 64'd1);
            send_frame(vl, nl, vr, nr, 1'b0, 1'b0);
            ngood += int'(is_good(nl, nr));
        end
        check("accept_count", 64'(n_acc - acc0), 64'(ngood));

        for (int i = 0; i < 10; i++) send_rise(1'b0, 1'($urandom));
        do_reset();
        lone_right(8);
        sample_ready = 1'b0;
        send_frame(64'h1111, 16, 64'h2222, 16, 1'b0, 1'b0);
        check("overrun_first", overrun, 0);
        send_frame(64'h3333, 16, 64'h4444, 16, 1'b1, 1'b0);
        check("overrun_set", overrun, 1);
        check("held_l", sample_l, 16'h3333);
        check("held_r", sample_r, 16'h4444);
        sample_ready = 1'b1;
        @(negedge clk);
        check("valid_cleared", sample_valid, 0);
        check("overrun_sticky", overrun, 1);

        do_reset();
        lone_right(8);
        sample_ready = 1'b0;
        send_frame(64'h5555, 16, 64'h6666, 16, 1'b0, 1'b0);
        send_frame(64'h7777, 16, 64'h8888, 16, 1'b1, 1'b1);
        @(negedge clk);
        check("same_cycle_valid", sample_valid, 1);
        check("same_cycle_l", sample_l, 16'h7777);
        check("same_cycle_r", sample_r, 16'h8888);
        check("same_cycle_overrun", overrun, 0);
        sample_ready = 1'b1;
        @(negedge clk);
        check("same_cycle_cleared", sample_valid, 0);

        acc0 = n_acc;
        send_frame({32'd0, 16'hC0DE, 16'($urandom)}, 32, {40'd0, 16'hBEEF, 8'($urandom)}, 24, 1'b0, 1'b0);
        send_frame({32'd0, 16'h0F0F, 16'($urandom)}, 32, {32'd0, 16'hF0F0, 16'($urandom)}, 32, 1'b0, 1'b0);
        check("len_check_accepts", 64'(n_acc - acc0), 64'(int'(is_good(32, 24)) + 1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/i2s_rx_deser.md
# i2s_rx_deser

I2S receive front-end for the DDC datapath: oversamples the asynchronous I2S pins (`bclk`, `lrclk`, `sdin`) on the system clock and deserialises each stereo frame into parallel left/right samples. Completed frames are presented on a valid/ready port. It sits directly upstream of the interpolation / sigma-delta stage that drives the PDM output.

## Interface
- `DATA_W`, 16: bits captured per channel, MSB-first, two's complement.
- `clk`  in  1  system clock; must be ≥ 4× `bclk`; `bclk` high and low phases each ≥ 2 `clk` periods.
- `rst_n`  in  1  synchronous, active-low reset.
- `bclk`  in  1  I2S bit clock, asynchronous to `clk`.
- `lrclk`  in  1  I2S word select, asynchronous; 0 = left, 1 = right.
- `sdin`  in  1  I2S serial data, asynchronous.
- `sample_l`  out  DATA_W  left sample of the last delivered frame.
- `sample_r`  out  DATA_W  right sample of the last delivered frame.
- `sample_valid`  out  1  frame available; held until accepted.
- `sample_ready`  in  1  consumer accepts the frame in any cycle where `sample_valid` & `sample_ready`.
- `overrun`  out  1  sticky; a frame completed while the previous frame was still unaccepted.
- `frame_err`  out  1  one-cycle pulse on a rejected frame; tied 0 unless the macro is defined.

## Operation
- Each pin passes through a 2-flop synchroniser. `bclk` also has a delay register. Rise strobe `brise` = synced `bclk` & ~delayed `bclk`.
- On each `brise`, the block samples synced `lrclk` (`lr`) and synced `sdin`, and compares `lr` with `lr_prev`, the `lr` value from the previous `brise`. A *transition rise* is a rise where `lr` != `lr_prev`.
- Slot = the rises after one transition rise, up to and including the next transition rise. The I2S one-bit delay therefore falls out of this definition: the bit on a transition rise is the LSB of the ending slot.
- Per slot, counter `cnt` (saturating) and shift register `sh`:
  - The first `DATA_W` bits are shifted in MSB-first; later bits are discarded.
  - If the slot has fewer than `DATA_W` bits, the latched word is left-justified with zero LSBs.
  - At a transition rise, the current bit is shifted in first (if `cnt` < `DATA_W`). The word is then latched, and `cnt` and `sh` are cleared.
- FSM:
  - HUNT: stay until a 1→0 transition rise, then go to LEFT. The bits seen in HUNT are discarded.
  - LEFT: on a 0→1 transition rise, latch the word into `hold_l` and go to RIGHT.
  - RIGHT: on a 1→0 transition rise, the latched word is the right sample. Load `sample_l` ← `hold_l` and `sample_r` ← word, set `sample_valid`, and go to LEFT.
- Handshake:
  - `sample_valid` stays 1 until a cycle with `sample_ready` = 1 and no new delivery, then clears.
  - Delivery in the same cycle as acceptance: the new data loads, `sample_valid` stays 1, `overrun` is unchanged.
  - Delivery while `sample_valid` = 1 and `sample_ready` = 0: the new frame overwrites the old one and `overrun` is set. `overrun` is cleared only by reset.
  - `sample_l` and `sample_r` are stable while `sample_valid` = 1 and no new delivery occurs.
- Reset values: `sample_l` = 0, `sample_r` = 0, `sample_valid` = 0, `overrun` = 0, `frame_err` = 0, FSM = HUNT. All synchroniser, `lr_prev`, `cnt`, `sh` and `hold_l` registers = 0.
- Reset asserted mid-frame: the partial frame is discarded. The next delivery requires a full left slot plus a full right slot after the next 1→0 transition rise.

## Timing
- Let E be the first `clk` edge that samples a `bclk` rise at the pin. The shift, latch, FSM and output update occur on edge E+2.
- `sample_valid` is high in the cycle after edge E+2 of the closing 1→0 transition rise.
- Latency from the pin `bclk` rise to `sample_valid`: 3 `clk` edges, plus up to 1 cycle of synchroniser uncertainty.
- `frame_err` is a one-cycle pulse, aligned to the cycle in which `sample_valid` would have been set.
- No combinational path from any input to any output.

## Configuration
- `I2S_RX_FRAME_CHECK_EN` defined:
  - The block tracks the full slot length of each slot (counter saturating at 63).
  - On the right-slot close, the frame is rejected if left length != right length, or if either length < `DATA_W`.
  - A rejected frame pulses `frame_err` for one cycle, sets no `sample_valid`, does not touch `overrun` or the output registers, and the FSM still goes to LEFT.
- Undefined: no length tracking, every frame is delivered, and `frame_err` is driven constant 0.

## Test plan
- Reset: hold `rst_n` = 0 for 3 cycles with pins toggling -> all outputs 0; no `sample_valid` during a subsequent lone right slot.
- `DATA_W` = 16, 32-bit slots, stimulus starts `lrclk` = 1, L = 0x1234, R = 0xABCD, pad bits random, `sample_ready` = 1 -> one pulse with `sample_l` = 0x1234, `sample_r` = 0xABCD, 3 edges after the closing transition rise.
- 12-bit slots, L = 0xABC, R = 0x123 -> `sample_l` = 0xABC0, `sample_r` = 0x1230.
- `sample_ready` = 0 across frames (0x1111, 0x2222) then (0x3333, 0x4444) -> `overrun` = 1, outputs 0x3333 / 0x4444, `sample_valid` held; raise `sample_ready` -> `sample_valid` clears next cycle, `overrun` stays 1.
- `sample_ready` pulsed exactly in the delivery cycle of frame 2 -> `sample_valid` stays 1 with frame 2 data, `overrun` = 0.
- With `I2S_RX_FRAME_CHECK_EN`, left slot 32 bits and right slot 24 bits -> `frame_err` pulses once, no `sample_valid`; the next 32/32 frame is delivered normally.
